instr_encode_loader: RTL and testbench
======================================

Name: instr_encode_loader

Overview:
- Encoder counterpart of the main control decoder: accepts decoded instruction fields (format, register indices, funct, immediate) over a valid/ready handshake.
- Packs them into a 32-bit RV32I instruction word and writes it sequentially into instruction memory.
- Used by the testbench/boot path to build programs without hand-assembled hex.
- Supported formats match the decoder: R-type, I-type ALU, Load, Store, Branch.

Parameters:
- IMEM_DEPTH, 256, number of 32-bit words in instruction memory (power of two).
- ADDR_W, 10, byte-address width of imem_addr; must satisfy 2^ADDR_W >= 4*IMEM_DEPTH.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  field bundle valid
- in_ready  out  1  loader can accept a bundle
- fmt  in  3  0=R, 1=I, 2=LOAD, 3=STORE, 4=BRANCH, 5..7 illegal
- rd  in  5  destination register
- rs1  in  5  source register 1
- rs2  in  5  source register 2
- funct3  in  3  funct3 field
- funct7  in  7  funct7 field (R only)
- imm  in  13  signed immediate; I/LOAD/STORE use imm[11:0]; BRANCH uses imm[12:1], imm[0] ignored
- clear  in  1  synchronous rewind of write address to 0
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  byte address, word aligned
- imem_wdata  out  32  encoded instruction
- full  out  1  IMEM_DEPTH words written
- err  out  1  sticky: illegal fmt received since reset/clear

Behaviour:
- Reset values: in_ready=0 during reset, then 1 in IDLE; imem_we=0, imem_addr=0, imem_wdata=0, full=0, err=0.
- FSM states: IDLE, ENC, WR, FULL.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture all fields and go to ENC.
- ENC:
  - in_ready=0.
  - Register encoded word into imem_wdata.
  - Legal fmt -> WR.
  - Illegal fmt -> set err, discard bundle, go to IDLE with address unchanged.
- WR:
  - imem_we=1 for exactly one cycle at the current imem_addr.
  - Next cycle: imem_addr += 4.
  - If the written word was index IMEM_DEPTH-1 -> FULL (full=1, address holds at last written word + 4 wrapped to 0). Else -> IDLE.
- FULL:
  - in_ready=0, full=1.
  - Only clear exits: address 0, full=0, -> IDLE.
- Latency and throughput: handshake at cycle T -> imem_we high at T+2; throughput one instruction per 3 cycles.
- clear:
  - In IDLE or FULL: address=0, err=0, full=0 next cycle.
  - In ENC/WR: ignored until return to IDLE. clear is level; sampled in IDLE.
- clear and in_valid both high in IDLE: clear wins; in_ready forced 0 that cycle.
- Encoding, with opcodes R=0110011, I=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011:
  - R: {funct7,rs2,rs1,funct3,rd,op}
  - I/LOAD: {imm[11:0],rs1,funct3,rd,op}
  - STORE: {imm[11:5],rs2,rs1,funct3,imm[4:0],op}
  - BRANCH: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op}
- Unused fields are ignored, e.g. rd for STORE.
- Async reset mid-operation: imem_we drops immediately; the in-flight bundle is lost; address returns to 0.

Optional Feature:
- Macro: INSTR_ENC_ILLEGAL_NOP_EN.
- Defined: illegal fmt still sets err, but ENC loads 32'h00000013 (addi x0,x0,0) and proceeds to WR, so the address advances.
- Undefined: illegal bundles are dropped with no write, as above.

Decomposition:
- Shared package riscv_pkg:
  - 7-bit opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH), shared with the control decoder.
  - fmt encoding constants.
  - NOP constant 32'h00000013.
- Sub-module instr_format_pack: purely combinational, fields+fmt -> 32-bit word plus illegal flag.
- instr_encode_loader holds FSM, capture registers, address counter.

Test Plan:
- Reset, then R add (fmt=0,rd=3,rs1=1,rs2=2,f3=0,f7=0) -> imem_we at T+2, addr 0x000, wdata 0x002081B3.
- Back-to-back I addi x5,x0,10 then LOAD lw x6,8(x1) -> 0x00A00293 @0x000 and 0x0080A303 @0x004; in_ready low for 2 cycles after each handshake.
- STORE sw x6,4(x1) -> 0x0060A223; BRANCH beq x1,x2,imm=-8 -> 0xFE208CE3.
- fmt=6 -> err=1; no imem_we and addr unchanged (macro undefined). With macro defined: wdata 0x00000013 written and addr +4.
- Write IMEM_DEPTH bundles -> full=1 and in_ready=0 after the last write; next in_valid is ignored; clear -> addr 0, full=0, err=0, in_ready=1.
- Assert rst_n=0 during WR -> imem_we falls same cycle; after release all outputs are at reset values.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants: opcodes, loader field-bundle format codes,
// canonical NOP and the loader FSM state type.
package riscv_pkg;

  // Major opcodes, shared with the control decoder
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Format selector carried with each field bundle; 5..7 are illegal
  localparam logic [2:0] FMT_R      = 3'd0;
  localparam logic [2:0] FMT_I      = 3'd1;
  localparam logic [2:0] FMT_LOAD   = 3'd2;
  localparam logic [2:0] FMT_STORE  = 3'd3;
  localparam logic [2:0] FMT_BRANCH = 3'd4;

  // addi x0, x0, 0
  localparam logic [31:0] INSTR_NOP = 32'h00000013;

  typedef enum logic [1:0] {
    StIdle,
    StEnc,
    StWr,
    StFull
  } loader_state_e;

endpackage

// File: rtl/instr_format_pack.sv
// Combinational packer: decoded fields + format -> 32-bit RV32I word.
// Unsupported formats yield an all-zero word and raise illegal.
module instr_format_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [12:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  // Select the bit layout for the requested format
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (fmt)
      FMT_R:      word = {funct7, rs2, rs1, funct3, rd, OP_R};
      FMT_I:      word = {imm[11:0], rs1, funct3, rd, OP_I};
      FMT_LOAD:   word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
      FMT_STORE:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
      // imm[0] is implicitly zero for branch offsets
      FMT_BRANCH: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Instruction encode/loader: accepts decoded field bundles over valid/ready,
// packs each into an RV32I word and writes it to the next imem word.
// Optional build macro INSTR_ENC_ILLEGAL_NOP_EN: illegal formats are written
// as a NOP (still flagging err) instead of being dropped.
module instr_encode_loader
  import riscv_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [12:0]       imm,
  input  logic              clear,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              full,
  output logic              err
);

  localparam int unsigned IdxW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(IMEM_DEPTH - 1);

  loader_state_e state_q, state_d;

  logic [2:0]      fmt_q;
  logic [4:0]      rd_q, rs1_q, rs2_q;
  logic [2:0]      funct3_q;
  logic [6:0]      funct7_q;
  logic [12:0]     imm_q;
  logic [31:0]     wdata_q;
  logic [IdxW-1:0] idx_q;
  logic            err_q;

  logic [31:0] packed_word;
  logic        packed_illegal;
  logic        accept;
  logic        rewind;

  instr_format_pack u_pack (
    .fmt     (fmt_q),
    .rd      (rd_q),
    .rs1     (rs1_q),
    .rs2     (rs2_q),
    .funct3  (funct3_q),
    .funct7  (funct7_q),
    .imm     (imm_q),
    .word    (packed_word),
    .illegal (packed_illegal)
  );

  // clear only acts in the resting states; it pre-empts a handshake in IDLE
  assign rewind = clear && ((state_q == StIdle) || (state_q == StFull));
  assign accept = in_valid && in_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (accept) state_d = StEnc;
      StEnc: begin
`ifdef INSTR_ENC_ILLEGAL_NOP_EN
        state_d = StWr;
`else
        state_d = packed_illegal ? StIdle : StWr;
`endif
      end
      StWr:   state_d = (idx_q == LastIdx) ? StFull : StIdle;
      StFull: if (clear) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state; in_ready held low while reset is asserted
  always_comb begin
    in_ready = rst_n && (state_q == StIdle) && !clear;
    imem_we  = (state_q == StWr);
    full     = (state_q == StFull);
  end

  // Capture registers, encoded word, write index and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fmt_q    <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      funct3_q <= '0;
      funct7_q <= '0;
      imm_q    <= '0;
      wdata_q  <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (rewind) begin
        idx_q <= '0;
        err_q <= 1'b0;
      end
      if (accept) begin
        fmt_q    <= fmt;
        rd_q     <= rd;
        rs1_q    <= rs1;
        rs2_q    <= rs2;
        funct3_q <= funct3;
        funct7_q <= funct7;
        imm_q    <= imm;
      end
      if (state_q == StEnc) begin
        if (packed_illegal) err_q <= 1'b1;
`ifdef INSTR_ENC_ILLEGAL_NOP_EN
        wdata_q <= packed_illegal ? INSTR_NOP : packed_word;
`else
        if (!packed_illegal) wdata_q <= packed_word;
`endif
      end
      // Power-of-two depth: the index wraps to 0 after the last word
      if (state_q == StWr) idx_q <= idx_q + 1'b1;
    end
  end

  assign imem_addr  = ADDR_W'({idx_q, 2'b00});
  assign imem_wdata = wdata_q;
  assign err        = err_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed self-checking bench for instr_encode_loader.
module tb_instr_encode_loader;

  localparam int unsigned IMEM_DEPTH = 256;
  localparam int unsigned ADDR_W     = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        fmt;
  logic [4:0]        rd, rs1, rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [12:0]       imm;
  logic              clear;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              full;
  logic              err;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int exp_idx     = 0;
  logic exp_err   = 1'b0;

  logic [45:0] obs, exp;

  instr_encode_loader #(
    .IMEM_DEPTH (IMEM_DEPTH),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fmt        (fmt),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .funct3     (funct3),
    .funct7     (funct7),
    .imm        (imm),
    .clear      (clear),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .full       (full),
    .err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Present a bundle from a falling edge and hold it until accepted (bounded)
  task automatic send(input logic [2:0] f, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [12:0] im, output bit ok, output int hs);
    @(negedge clk);
    fmt = f; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    hs = cyc;
    #1 in_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0;
    fmt = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    #12;
    obs = {in_ready, imem_we, imem_addr, imem_wdata, full, err};
    exp = {1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL reset_during: got %h want %h", obs, exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    obs = {in_ready, imem_we, imem_addr, imem_wdata, full, err};
    exp = {1'b1, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL reset_release: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_r_type();
    bit ok;
    int hs;
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'h0, ok, hs);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL r_handshake: in_ready never rose got 0 want 1");
    end
    @(negedge clk);  // ENC
    vectors++;
    if ({in_ready, imem_we} !== 2'b00) begin
      miscompares++;
      $display("FAIL r_enc_cycle: got ready/we=%b want 00", {in_ready, imem_we});
    end
    @(negedge clk);  // WR, T+2
    obs = {in_ready, imem_we, imem_addr, imem_wdata, full, err};
    exp = {1'b0, 1'b1, 10'h000, 32'h002081B3, 1'b0, 1'b0};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL r_write: got %h want %h", obs, exp);
    end
    @(negedge clk);
    obs = {in_ready, imem_we, imem_addr, imem_wdata, full, err};
    exp = {1'b1, 1'b0, 10'h004, 32'h002081B3, 1'b0, 1'b0};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL r_after: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  v_fmt [2] = '{3'd1, 3'd2};
    logic [4:0]  v_rd  [2] = '{5'd5, 5'd6};
    logic [4:0]  v_rs1 [2] = '{5'd0, 5'd1};
    logic [2:0]  v_f3  [2] = '{3'd0, 3'd2};
    logic [12:0] v_imm [2] = '{13'd10, 13'd8};
    logic [31:0] v_exp [2] = '{32'h00A00293, 32'h0080A303};
    bit ok;
    int hs, prev_hs;
    pulse_clear();
    exp_idx = 0;
    prev_hs = 0;
    for (int i = 0; i < 2; i++) begin
      // junk rs2/funct7 must not leak into I/LOAD words
      send(v_fmt[i], v_rd[i], v_rs1[i], 5'd31, v_f3[i], 7'h7F, v_imm[i], ok, hs);
      vectors++;
      if (!ok || (i == 1 && hs - prev_hs != 3)) begin
        miscompares++;
        $display("FAIL b2b_handshake%0d: ok=%0d spacing %0d want 3", i, ok, hs - prev_hs);
      end
      prev_hs = hs;
      @(negedge clk);
      vectors++;
      if ({in_ready, imem_we} !== 2'b00) begin
        miscompares++;
        $display("FAIL b2b_enc%0d: got ready/we=%b want 00", i, {in_ready, imem_we});
      end
      @(negedge clk);
      obs = {in_ready, imem_we, imem_addr, imem_wdata, full, err};
      exp = {1'b0, 1'b1, ADDR_W'(exp_idx * 4), v_exp[i], 1'b0, 1'b0};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL b2b_write%0d: got %h want %h", i, obs, exp);
      end
      exp_idx++;
    end
  endtask

  task automatic test_store_branch();
    logic [2:0]  v_fmt [2] = '{3'd3, 3'd4};
    logic [4:0]  v_rd  [2] = '{5'd31, 5'd7};
    logic [4:0]  v_rs1 [2] = '{5'd1, 5'd1};
    logic [4:0]  v_rs2 [2] = '{5'd6, 5'd2};
    logic [2:0]  v_f3  [2] = '{3'd2, 3'd0};
    logic [12:0] v_imm [2] = '{13'd4, 13'h1FF8};
    logic [31:0] v_exp [2] = '{32'h0060A223, 32'hFE208CE3};
    bit ok;
    int hs;
    for (int i = 0; i < 2; i++) begin
      send(v_fmt[i], v_rd[i], v_rs1[i], v_rs2[i], v_f3[i], 7'h55, v_imm[i], ok, hs);
      @(negedge clk);
      @(negedge clk);
      obs = {in_ready, imem_we, imem_addr, imem_wdata, full, err};
      exp = {1'b0, 1'b1, ADDR_W'(exp_idx * 4), v_exp[i], 1'b0, 1'b0};
      vectors++;
      if (!ok || obs !== exp) begin
        miscompares++;
        $display("FAIL sb_write%0d: ok=%0d got %h want %h", i, ok, obs, exp);
      end
      exp_idx++;
    end
  endtask

  task automatic test_illegal();
    bit ok;
    int hs;
    int we_seen = 0;
    logic [ADDR_W-1:0] a0;
    a0 = ADDR_W'(exp_idx * 4);
    send(3'd6, 5'd1, 5'd2, 5'd3, 3'd1, 7'd1, 13'd1, ok, hs);
    @(negedge clk);  // ENC
    if (imem_we) we_seen++;
    @(negedge clk);
`ifdef INSTR_ENC_ILLEGAL_NOP_EN
    obs = {in_ready, imem_we, imem_addr, imem_wdata, full, err};
    exp = {1'b0, 1'b1, a0, 32'h00000013, 1'b0, 1'b1};
    vectors++;
    if (!ok || we_seen != 0 || obs !== exp) begin
      miscompares++;
      $display("FAIL illegal_nop_write: ok=%0d got %h want %h", ok, obs, exp);
    end
    exp_idx++;
    @(negedge clk);
    vectors++;
    if ({in_ready, imem_addr, err} !== {1'b1, ADDR_W'(exp_idx * 4), 1'b1}) begin
      miscompares++;
      $display("FAIL illegal_nop_after: got ready=%b addr=%h err=%b want 1 %h 1",
               in_ready, imem_addr, err, ADDR_W'(exp_idx * 4));
    end
`else
    if (imem_we) we_seen++;
    @(negedge clk);
    if (imem_we) we_seen++;
    obs = {in_ready, imem_we, imem_addr, 32'h0, full, err};
    exp = {1'b1, 1'b0, a0, 32'h0, 1'b0, 1'b1};
    vectors++;
    if (!ok || we_seen != 0 || obs !== exp) begin
      miscompares++;
      $display("FAIL illegal_drop: ok=%0d we_seen=%0d got %h want %h", ok, we_seen, obs, exp);
    end
`endif
    exp_err = 1'b1;
  endtask

  task automatic test_full();
    bit ok;
    int hs;
    int bad = 0;
    int we_seen = 0;
    logic [31:0] w;
    while (exp_idx < int'(IMEM_DEPTH)) begin
      w = {20'h0, 5'(exp_idx), 7'b0110011};
      send(3'd0, 5'(exp_idx), 5'd0, 5'd0, 3'd0, 7'd0, 13'd0, ok, hs);
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (!ok || {imem_we, imem_addr, imem_wdata, full} !== {1'b1, ADDR_W'(exp_idx * 4), w, 1'b0}) begin
        miscompares++;
        bad++;
        if (bad < 5)
          $display("FAIL fill_write%0d: ok=%0d we=%b addr=%h data=%h want addr=%h data=%h",
                   exp_idx, ok, imem_we, imem_addr, imem_wdata, ADDR_W'(exp_idx * 4), w);
      end
      exp_idx++;
    end
    @(negedge clk);
    obs = {in_ready, imem_we, imem_addr, 32'h0, full, err};
    exp = {1'b0, 1'b0, 10'h000, 32'h0, 1'b1, exp_err};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL full_reached: got %h want %h", obs, exp);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (imem_we || in_ready || !full) we_seen++;
    end
    in_valid = 1'b0;
    vectors++;
    if (we_seen != 0) begin
      miscompares++;
      $display("FAIL full_ignores_valid: got %0d bad cycles want 0", we_seen);
    end
    pulse_clear();
    @(negedge clk);
    obs = {in_ready, imem_we, imem_addr, 32'h0, full, err};
    exp = {1'b1, 1'b0, 10'h000, 32'h0, 1'b0, 1'b0};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL full_clear: got %h want %h", obs, exp);
    end
    exp_idx = 0;
    exp_err = 1'b0;
  endtask

  task automatic test_clear_priority();
    int we_seen = 0;
    @(negedge clk);
    fmt = 3'd0; rd = 5'd9;
    clear = 1'b1;
    in_valid = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_wins_ready: got %b want 0", in_ready);
    end
    @(posedge clk);
    #1 clear = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (imem_we || imem_addr != '0 || !in_ready) we_seen++;
    end
    vectors++;
    if (we_seen != 0) begin
      miscompares++;
      $display("FAIL clear_wins_no_write: got %0d bad cycles want 0", we_seen);
    end
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    int hs;
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'h0, ok, hs);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (!ok || imem_we !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre_we: ok=%0d got we=%b want 1", ok, imem_we);
    end
    #1 rst_n = 1'b0;
    #1;
    obs = {in_ready, imem_we, imem_addr, imem_wdata, full, err};
    exp = {1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL rst_async_drop: got %h want %h", obs, exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    obs = {in_ready, imem_we, imem_addr, imem_wdata, full, err};
    exp = {1'b1, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL rst_after_release: got %h want %h", obs, exp);
    end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_back_to_back();
    test_store_branch();
    test_illegal();
    test_full();
    test_clear_priority();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
